// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// The serial input is brought into the clock domain through a two-flop
// synchronizer that is preset to the idle level. A five-state FSM
// (IDLE, START, DATA, STOP, CLEANUP) samples each bit near its centre. It
// recovers the byte and reports either a one-cycle valid pulse or a
// one-cycle framing-error pulse. o_rx_data holds the last good byte.
//
// Parameters
//   CLOCKS_PER_BIT  i_clk cycles per UART bit (>= 4), default 434.
//
// Ports
//   i_clk            in   1  rising-edge clock
//   i_rst            in   1  synchronous active-high reset
//   i_rx_bit         in   1  asynchronous serial line
//   o_rx_data        out  8  last correctly framed byte
//   o_rx_data_valid  out  1  one-cycle pulse when o_rx_data updates
//   o_rx_active      out  1  high while a frame is in progress
//   o_framing_error  out  1  one-cycle pulse when the stop bit is low
//   o_rx_state       out  3  current FSM state code (debug)
//   o_bit_index      out  3  current data-bit index (debug)
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_bit,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  output logic       o_rx_active,
  output logic       o_framing_error,
  output logic [2:0] o_rx_state,
  output logic [2:0] o_bit_index
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  // The start bit is checked half a bit in, so that data and stop
  // samples then fall near the centre of each following bit.
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_e;

  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             ferr_q;
  logic             ferr_d;
  logic             active_q;
  logic             active_d;

  // Two-flop synchronizer. It is preset to the idle level so that a
  // reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx_bit;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Next-state logic, counters, shift register and output pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        if (rx_s == 1'b0) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = {CNT_W{1'b0}};
          // If the line is high again at mid start bit, the low level
          // was a glitch. Drop back to IDLE without any pulse.
          if (rx_s == 1'b0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d            = {CNT_W{1'b0}};
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_CLEANUP;
          // A low stop bit is a framing error. The previously
          // delivered byte stays on o_rx_data.
          if (rx_s == 1'b1) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_CLEANUP: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        state_d   = S_IDLE;
      end

      default: begin
        // Unused codes 5-7 recover to IDLE.
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        state_d   = S_IDLE;
      end
    endcase

    active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
  end

  // State and datapath registers. Reset has priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      active_q  <= active_d;
    end
  end

  assign o_rx_data       = data_q;
  assign o_rx_data_valid = valid_q;
  assign o_framing_error = ferr_q;
  assign o_rx_active     = active_q;
  assign o_rx_state      = state_q;
  assign o_bit_index     = bit_idx_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 4 clocks per bit.
//
// The whole line waveform and reset pattern are laid out per clock edge in
// arrays first. A behavioural receiver model then derives the expected
// outputs for every edge from bit-timing arithmetic. The model works
// relative to the detected falling edge and does not use the DUT's
// counters. The run drives the arrays and compares all outputs after every
// edge. A set of hand-computed literal expectations then pins the model
// and the DUT: latency, pulse data list, spacing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int H    = (CPB - 1) / 2;
  localparam int NMAX = 12000;
  localparam int LAT  = 40;   // line index of start low -> valid edge (2+1+1+36)

  logic       clk;
  logic       i_rst;
  logic       i_rx_bit;
  logic [7:0] o_rx_data;
  logic       o_rx_data_valid;
  logic       o_rx_active;
  logic       o_framing_error;
  logic [2:0] o_rx_state;
  logic [2:0] o_bit_index;

  uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_rx_bit        (i_rx_bit),
    .o_rx_data       (o_rx_data),
    .o_rx_data_valid (o_rx_data_valid),
    .o_rx_active     (o_rx_active),
    .o_framing_error (o_framing_error),
    .o_rx_state      (o_rx_state),
    .o_bit_index     (o_bit_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus per edge
  logic line_a [NMAX];
  logic rst_a  [NMAX];
  int   n;

  // model expectations per edge (value seen after that edge)
  int exp_valid [NMAX];
  int exp_ferr  [NMAX];
  int exp_data  [NMAX];
  int exp_act   [NMAX];
  int exp_state [NMAX];
  int exp_bidx  [NMAX];

  // DUT observations
  int d_data  [NMAX];
  int d_state [NMAX];
  int d_act   [NMAX];
  int v_edge [$];
  int v_data [$];
  int f_edge [$];
  int lit    [$];

  int checks;
  int errors;

  task automatic check(string name, int act, int expv, int e);
    checks++;
    if (act != expv) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, expv);
    end
  endtask

  task automatic put(logic v, logic r);
    line_a[n] = v;
    rst_a[n]  = r;
    n++;
  endtask

  task automatic idle(int c);
    for (int i = 0; i < c; i++) put(1'b1, 1'b0);
  endtask

  task automatic frame(logic [7:0] b, logic stop_bit);
    for (int i = 0; i < CPB; i++) put(1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) put(b[k], 1'b0);
    for (int i = 0; i < CPB; i++) put(stop_bit, 1'b0);
  endtask

  // Synchronized line value seen by the receiver at edge e. The sync
  // stages read idle for two edges after any reset edge.
  function automatic logic rxs(int e);
    if (e < 2) return 1'b1;
    if (rst_a[e-1] || rst_a[e-2]) return 1'b1;
    return line_a[e-2];
  endfunction

  // Behavioural receiver. A start is detected at edge d. The start bit is
  // rechecked at d+H+1. Data bit i is taken at d+H+1+(i+1)*CPB and the
  // stop bit at d+H+1+9*CPB, where the pulse is produced. The next start
  // can be seen two edges later.
  function automatic void run_model();
    int d     = -1;
    int ready = 0;
    int off;
    int st;
    int bi;
    logic [7:0] shreg = 8'h00;
    logic [7:0] data  = 8'h00;
    for (int e = 0; e < n; e++) begin
      exp_valid[e] = 0;
      exp_ferr[e]  = 0;
      st = 0;
      bi = 0;
      if (rst_a[e]) begin
        d     = -1;
        ready = e + 1;
        data  = 8'h00;
      end else begin
        if (d < 0 && e >= ready && rxs(e) == 1'b0) d = e;
        if (d >= 0) begin
          off = e - d;
          if (off > H + 1 && off <= H + 1 + 8*CPB && (off - H - 1) % CPB == 0)
            shreg[(off - H - 1) / CPB - 1] = rxs(e);
          if (off <= H) begin
            st = 1;
          end else if (off == H + 1 && rxs(e) == 1'b1) begin
            st = 0;
            d = -1;
            ready = e + 1;
          end else if (off < H + 1 + 8*CPB) begin
            st = 2;
            bi = (off - H - 1) / CPB;
          end else if (off < H + 1 + 9*CPB) begin
            st = 3;
          end else begin
            st = 4;
            if (rxs(e) == 1'b1) begin
              data = shreg;
              exp_valid[e] = 1;
            end else begin
              exp_ferr[e] = 1;
            end
            d = -1;
            ready = e + 2;
          end
        end
      end
      exp_state[e] = st;
      exp_bidx[e]  = bi;
      exp_data[e]  = int'(data);
      exp_act[e]   = (st >= 1 && st <= 3) ? 1 : 0;
    end
  endfunction

  int s_a5, g_lo, s_3c, s_00, s_5a, r_5a, s_81, s_lb;
  int model_pulses;

  initial begin
    checks   = 0;
    errors   = 0;
    n        = 0;
    i_rst    = 1'b1;
    i_rx_bit = 1'b1;

    // ---- build the stimulus -------------------------------------------
    for (int i = 0; i < 4; i++) put(1'b1, 1'b1);
    idle(8);
    s_a5 = n; frame(8'hA5, 1'b1);
    idle(8);
    g_lo = n; put(1'b0, 1'b0); idle(12);            // one-clock glitch
    s_3c = n; frame(8'h3C, 1'b0);                    // stop bit low
    idle(8);
    s_00 = n; frame(8'h00, 1'b1); frame(8'hFF, 1'b1);
    idle(8);
    s_5a = n; frame(8'h5A, 1'b1);
    r_5a = s_5a + CPB + 3*CPB + 1;                   // inside data bit 3
    rst_a[r_5a] = 1'b1;
    idle(12*CPB);
    s_81 = n; frame(8'h81, 1'b1);
    idle(8);
    s_lb = n;
    for (int b = 0; b < 256; b++) frame(8'(b), 1'b1);
    idle(16);

    // The reset leaves bits 4..7 and the stop bit of 0x5A on the line.
    // The low bit 5 is taken as a start bit. Bit 6 (1), bit 7 (0) and the
    // stop bit (1) then become data bits 0..2, and idle fills the rest,
    // giving 0xFD.
    lit.push_back(8'hA5); lit.push_back(8'h00); lit.push_back(8'hFF);
    lit.push_back(8'hFD); lit.push_back(8'h81);
    for (int b = 0; b < 256; b++) lit.push_back(b);

    run_model();

    // ---- run and compare every edge -----------------------------------
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      i_rx_bit = line_a[e];
      i_rst    = rst_a[e];
      @(posedge clk);
      #1;
      d_data[e]  = int'(o_rx_data);
      d_state[e] = int'(o_rx_state);
      d_act[e]   = int'(o_rx_active);
      if (o_rx_data_valid) begin
        v_edge.push_back(e);
        v_data.push_back(int'(o_rx_data));
      end
      if (o_framing_error) f_edge.push_back(e);
      check("rx_data",       int'(o_rx_data),       exp_data[e],  e);
      check("rx_data_valid", int'(o_rx_data_valid), exp_valid[e], e);
      check("framing_error", int'(o_framing_error), exp_ferr[e],  e);
      check("rx_active",     int'(o_rx_active),     exp_act[e],   e);
      check("rx_state",      int'(o_rx_state),      exp_state[e], e);
      check("bit_index",     int'(o_bit_index),     exp_bidx[e],  e);
    end

    // ---- hand-computed literal expectations ---------------------------
    model_pulses = 0;
    for (int e = 0; e < n; e++) model_pulses += exp_valid[e];
    check("model_pulse_count", model_pulses, 261, 0);

    check("reset_data",  d_data[3],  0, 3);
    check("reset_state", d_state[3], 0, 3);
    check("reset_act",   d_act[3],   0, 3);

    check("valid_count", v_edge.size(), 261, 0);
    for (int i = 0; i < v_data.size() && i < lit.size(); i++)
      check("valid_data", v_data[i], lit[i], i);

    if (v_edge.size() >= 5) begin
      check("latency_a5",   v_edge[0], s_a5 + LAT, 0);
      check("b2b_spacing",  v_edge[2] - v_edge[1], 10*CPB, 0);
      check("latency_00",   v_edge[1], s_00 + LAT, 0);
      check("latency_81",   v_edge[4], s_81 + LAT, 0);
    end
    if (v_edge.size() == 261)
      check("loopback_span", v_edge[260] - v_edge[5], 255*10*CPB, 0);

    check("ferr_count", f_edge.size(), 1, 0);
    if (f_edge.size() >= 1)
      check("ferr_edge", f_edge[0], s_3c + LAT, 0);
    check("data_kept_after_ferr", d_data[s_3c + LAT + 1], 8'hA5, s_3c + LAT + 1);

    check("glitch_start", d_state[g_lo + 2],     1, g_lo + 2);
    check("glitch_idle",  d_state[g_lo + 2 + H + 1], 0, g_lo + 3 + H);

    check("midreset_data",  d_data[r_5a],  0, r_5a);
    check("midreset_act",   d_act[r_5a],   0, r_5a);
    check("midreset_state", d_state[r_5a], 0, r_5a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
